// File: rtl/zymason_pkg.sv
// Shared constants and control-state encoding for the zymason segment bank.
package zymason_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned LO_W  = 4;
    localparam int unsigned HI_W  = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT = 2'd0;
    localparam state_t ST_SCAN = 2'd1;
    localparam state_t ST_WLO  = 2'd2;
    localparam state_t ST_WHI  = 2'd3;

endpackage

// File: rtl/zymason_scan_tick.sv
// Scan pulse generator: free-running prescaler, programmable divide counter and one-clock pulse.
// Exposes the prescaler tick only when ZYMASON_BLINK_EN is defined.
module zymason_scan_tick #(
    parameter int unsigned PRE_W = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] spd,
`ifdef ZYMASON_BLINK_EN
    output logic       tick,
`endif
    output logic       pulse
);

    logic [PRE_W-1:0] pre_q;
    logic [3:0]       div_q;
    logic             tick_w;

    assign tick_w = (pre_q == '0);
    // Divisor is compared for equality only, so a divisor lowered below the count wraps first.
    assign pulse  = tick_w & spd[0] & (div_q == spd[4:1]);

`ifdef ZYMASON_BLINK_EN
    assign tick = tick_w;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else if (pulse) begin
            div_q <= '0;
        end else if (tick_w & spd[0]) begin
            div_q <= div_q + 4'd1;
        end
    end

endmodule

// File: rtl/zymason_seg_bank.sv
// Multi-digit seven-segment storage bank with nibble-wise writes and a rotating scan select.
// Define ZYMASON_BLINK_EN to blank seg_out on alternate ticks while writing.
module zymason_seg_bank
    import zymason_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRE_W      = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rw,
    input  logic                  sel,
    input  logic [3:0]            pin_in,
    input  logic [4:0]            spd,
    output logic [SEG_W-1:0]      seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  mode_out
);

    state_t                  state_q, state_d;
    logic [NUM_DIGITS-1:0]   dig_en_q;
    logic [SEG_W-1:0]        digit_q [NUM_DIGITS];
    logic [SEG_W-1:0]        seg_sel;
    logic                    pulse;
    logic                    advance;

`ifdef ZYMASON_BLINK_EN
    logic tick;
    logic blink_q;
`endif

    zymason_scan_tick #(
        .PRE_W(PRE_W)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .spd  (spd),
`ifdef ZYMASON_BLINK_EN
        .tick (tick),
`endif
        .pulse(pulse)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = rw ? ST_WLO : ST_SCAN;
            ST_SCAN: state_d = rw ? ST_WLO : ST_SCAN;
            ST_WLO:  state_d = sel ? ST_WHI : ST_WLO;
            ST_WHI:  state_d = rw ? (sel ? ST_WHI : ST_WLO) : ST_SCAN;
            default: state_d = ST_INIT;
        endcase
    end

    assign advance = ((state_q == ST_SCAN) & ~rw & pulse) |
                     ((state_q == ST_WHI) & rw & ~sel);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dig_en_q <= NUM_DIGITS'(1);
        end else if (advance) begin
            dig_en_q <= {dig_en_q[NUM_DIGITS-2:0], dig_en_q[NUM_DIGITS-1]};
        end
    end

    // Writes use the pre-advance select, so the falling-sel step lands on the old digit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                digit_q[i] <= '0;
            end
        end else if (rw) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (dig_en_q[i]) begin
                    if (sel) begin
                        digit_q[i][SEG_W-1:LO_W] <= pin_in[HI_W-1:0];
                    end else begin
                        digit_q[i][LO_W-1:0] <= pin_in;
                    end
                end
            end
        end
    end

    always_comb begin
        seg_sel = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (dig_en_q[i]) begin
                seg_sel = seg_sel | digit_q[i];
            end
        end
    end

`ifdef ZYMASON_BLINK_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else if (tick) begin
            blink_q <= ~blink_q;
        end
    end

    assign seg_out = (blink_q && ((state_q == ST_WLO) || (state_q == ST_WHI))) ? '0 : seg_sel;
`else
    assign seg_out = seg_sel;
`endif

    assign dig_en   = dig_en_q;
    assign mode_out = rw;

endmodule

// File: tb/tb_zymason_seg_bank.sv
// Self-checking bench for zymason_seg_bank with a scoreboard of expected scan steps.
module tb_zymason_seg_bank;
    import zymason_pkg::*;

    localparam int unsigned ND = 4;
    localparam int unsigned PW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rw = 1'b0;
    logic          sel = 1'b0;
    logic [3:0]    pin_in = 4'h0;
    logic [4:0]    spd = 5'b0;
    logic [6:0]    seg_out;
    logic [ND-1:0] dig_en;
    logic          mode_out;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [ND-1:0] dig;
        logic [6:0]    seg;
    } exp_t;

    exp_t sb[$];

    zymason_seg_bank #(
        .NUM_DIGITS(ND),
        .PRE_W     (PW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rw      (rw),
        .sel     (sel),
        .pin_in  (pin_in),
        .spd     (spd),
        .seg_out (seg_out),
        .dig_en  (dig_en),
        .mode_out(mode_out)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [4:0] s);
        rw = 1'b0;
        sel = 1'b0;
        pin_in = 4'h0;
        spd = s;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic write_digit(input logic [6:0] v);
        rw = 1'b1;
        sel = 1'b0;
        pin_in = v[3:0];
        step();
        sel = 1'b1;
        pin_in = {1'b0, v[6:4]};
        step();
        sel = 1'b0;
        pin_in = v[3:0];
        step();
    endtask

    // Follows dig_en until the scoreboard drains; optionally checks seg_out and the 8-clock spacing.
    task automatic drain_scan(input bit check_seg, input bit check_gap, input string tag);
        logic [ND-1:0] prev;
        int cyc;
        int last;
        exp_t e;
        prev = dig_en;
        cyc = 0;
        last = -1;
        while (sb.size() > 0 && cyc < 200) begin
            step();
            cyc++;
            if (dig_en !== prev) begin
                e = sb.pop_front();
                total++;
                if (dig_en !== e.dig) begin
                    bad++;
                    $display("FAIL %s dig_en: got %b want %b", tag, dig_en, e.dig);
                end
                if (check_seg) begin
                    total++;
                    if (seg_out !== e.seg) begin
                        bad++;
                        $display("FAIL %s seg_out: got %h want %h", tag, seg_out, e.seg);
                    end
                end
                if (check_gap && last >= 0) begin
                    total++;
                    if (cyc - last != 8) begin
                        bad++;
                        $display("FAIL %s pulse spacing: got %0d want 8", tag, cyc - last);
                    end
                end
                last = cyc;
                prev = dig_en;
            end
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s timeout: got %0d pending want 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        do_reset(5'b0);
        total++;
        if (seg_out !== 7'h00) begin
            bad++;
            $display("FAIL reset seg_out: got %h want 00", seg_out);
        end
        total++;
        if (dig_en !== 4'b0001) begin
            bad++;
            $display("FAIL reset dig_en: got %b want 0001", dig_en);
        end
        total++;
        if (dut.state_q !== ST_INIT) begin
            bad++;
            $display("FAIL reset state: got %0d want %0d", dut.state_q, ST_INIT);
        end
        total++;
        if (mode_out !== 1'b0) begin
            bad++;
            $display("FAIL mode_out low: got %b want 0", mode_out);
        end
        rw = 1'b1;
        #1;
        total++;
        if (mode_out !== 1'b1) begin
            bad++;
            $display("FAIL mode_out high: got %b want 1", mode_out);
        end
        rw = 1'b0;
    endtask

    task automatic test_scan_rate();
        do_reset(5'b00011);
        sb.push_back('{dig: 4'b0010, seg: 7'h00});
        sb.push_back('{dig: 4'b0100, seg: 7'h00});
        sb.push_back('{dig: 4'b1000, seg: 7'h00});
        sb.push_back('{dig: 4'b0001, seg: 7'h00});
        drain_scan(1'b0, 1'b1, "scan_rate");
    endtask

    task automatic test_write();
        do_reset(5'b0);
        rw = 1'b1;
        sel = 1'b0;
        pin_in = 4'hA;
        step();
        total++;
        if (dut.digit_q[0] !== 7'h0A) begin
            bad++;
            $display("FAIL write lo: got %h want 0a", dut.digit_q[0]);
        end
        sel = 1'b1;
        pin_in = 4'h5;
        step();
        total++;
        if (dut.digit_q[0] !== 7'h5A || dig_en !== 4'b0001) begin
            bad++;
            $display("FAIL write hi: got %h/%b want 5a/0001", dut.digit_q[0], dig_en);
        end
        sel = 1'b0;
        pin_in = 4'hA;
        step();
        total++;
        if (dut.digit_q[0] !== 7'h5A) begin
            bad++;
            $display("FAIL write hold: got %h want 5a", dut.digit_q[0]);
        end
        total++;
        if (dig_en !== 4'b0010) begin
            bad++;
            $display("FAIL write advance: got %b want 0010", dig_en);
        end
        rw = 1'b0;
    endtask

    task automatic test_scan_values();
        do_reset(5'b0);
        write_digit(7'h11);
        write_digit(7'h22);
        write_digit(7'h33);
        write_digit(7'h44);
        rw = 1'b0;
        sel = 1'b1;
        step();
        sel = 1'b0;
        step();
        total++;
        if (dut.state_q !== ST_SCAN || dig_en !== 4'b0001 || seg_out !== 7'h11) begin
            bad++;
            $display("FAIL scan entry: got st=%0d dig=%b seg=%h want st=%0d dig=0001 seg=11",
                     dut.state_q, dig_en, seg_out, ST_SCAN);
        end
        sb.push_back('{dig: 4'b0010, seg: 7'h22});
        sb.push_back('{dig: 4'b0100, seg: 7'h33});
        sb.push_back('{dig: 4'b1000, seg: 7'h44});
        sb.push_back('{dig: 4'b0001, seg: 7'h11});
        spd = 5'b00011;
        drain_scan(1'b1, 1'b0, "scan_values");
    endtask

    task automatic test_freeze();
        logic [ND-1:0] hold_dig;
        logic [3:0]    hold_div;
        bit            seen;
        spd = 5'b00011;
        repeat (5) step();
        spd = 5'b00010;
        #1;
        hold_dig = dig_en;
        hold_div = dut.u_tick.div_q;
        seen = 1'b0;
        repeat (100) begin
            step();
            if (dut.u_tick.pulse) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL freeze pulse: got %b want 0", seen);
        end
        total++;
        if (dig_en !== hold_dig) begin
            bad++;
            $display("FAIL freeze dig_en: got %b want %b", dig_en, hold_dig);
        end
        total++;
        if (dut.u_tick.div_q !== hold_div) begin
            bad++;
            $display("FAIL freeze divider: got %h want %h", dut.u_tick.div_q, hold_div);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset(5'b0);
        rw = 1'b1;
        sel = 1'b0;
        pin_in = 4'h7;
        step();
        sel = 1'b1;
        pin_in = 4'h3;
        #2;
        reset = 1'b1;
        step();
        step();
        rw = 1'b0;
        sel = 1'b0;
        reset = 1'b0;
        #1;
        for (int i = 0; i < int'(ND); i++) begin
            total++;
            if (dut.digit_q[i] !== 7'h00) begin
                bad++;
                $display("FAIL mid_reset digit%0d: got %h want 00", i, dut.digit_q[i]);
            end
        end
        total++;
        if (dig_en !== 4'b0001 || seg_out !== 7'h00) begin
            bad++;
            $display("FAIL mid_reset outputs: got %b/%h want 0001/00", dig_en, seg_out);
        end
        total++;
        if (dut.state_q !== ST_INIT) begin
            bad++;
            $display("FAIL mid_reset state: got %0d want %0d", dut.state_q, ST_INIT);
        end
    endtask

    task automatic test_blink();
        int zeros;
        int lits;
        do_reset(5'b0);
        rw = 1'b1;
        sel = 1'b0;
        pin_in = 4'hF;
        step();
        sel = 1'b1;
        pin_in = 4'h3;
        step();
        zeros = 0;
        lits = 0;
        for (int c = 0; c < 16; c++) begin
            step();
`ifdef ZYMASON_BLINK_EN
            if (seg_out === 7'h00) zeros++;
            else if (seg_out === 7'h3F) lits++;
`else
            total++;
            if (seg_out !== 7'h3F) begin
                bad++;
                $display("FAIL steady seg_out cycle %0d: got %h want 3f", c, seg_out);
            end
`endif
        end
`ifdef ZYMASON_BLINK_EN
        total++;
        if (zeros != 8 || lits != 8) begin
            bad++;
            $display("FAIL blink duty: got zeros=%0d lit=%0d want 8/8", zeros, lits);
        end
`endif
        rw = 1'b0;
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_rate();
        test_write();
        test_scan_values();
        test_freeze();
        test_reset_mid_write();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
